// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: state encodings,
// parity modes, error pulse bundle and the baud divisor helper.
package uart_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_PUSH      = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } rx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // One-cycle error indications; at most one field is set per frame.
    typedef struct packed {
        logic frame;
        logic parity;
        logic overrun;
    } rx_err_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        int unsigned den;
        den = baud_rate * oversample;
        return (clk_freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO holding received words until the
// consumer takes them. Push is ignored when full unless a pop frees a slot
// in the same cycle; pop is ignored when empty.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             push_en_c, pop_en_c;

    assign pop_en_c  = pop_i && valid_q;
    assign push_en_c = push_i && (!full_q || pop_en_c);

    // Pointer, occupancy and status flag update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_en_c) - CNT_W'(pop_en_c);
        valid_d = (count_d != '0);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    // Storage; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_en_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = valid_q;
    assign full_o  = full_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF input synchroniser, oversampled tick
// generator with 3-sample majority voting, framing FSM with parity and
// stop-bit checking, and a FWFT output FIFO with valid/ready drain.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 2,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_raw,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun,
    output logic [2:0]           rx_state
);

    localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TC_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BC_W  = 4;

    logic                 sync1_q, sync2_q;
    logic                 rx_s;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 tick_c;
    logic                 align_c;
    logic [1:0]           hist_q, hist_d;
    logic                 maj_c;
    logic                 mid_c, sample_c;
    logic                 par_exp_c;
    rx_state_e            state_q, state_d;
    logic [TC_W-1:0]      tc_q, tc_d;
    logic [BC_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    rx_err_t              err_q, err_d;
    logic                 push_c, pop_c;
    logic                 fifo_full;

    // Two-stage synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_raw;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Tick divider; restarted on a start edge so ticks are frame-aligned.
    always_comb begin
        tick_c = (div_q == DIV_W'(DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);
        if (align_c) begin
            div_d = '0;
        end
        hist_d = tick_c ? {hist_q[0], rx_s} : hist_q;
    end

    // Divider and sample history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            hist_q <= '0;
        end else begin
            div_q  <= div_d;
            hist_q <= hist_d;
        end
    end

    // Majority of the two previous ticks and the current one.
    assign maj_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);

    assign mid_c    = tick_c && (tc_q == TC_W'(OVERSAMPLE / 2 - 1));
    assign sample_c = tick_c && (tc_q == TC_W'(OVERSAMPLE - 1));

    // Expected parity bit for the word currently in the shift register.
    assign par_exp_c = (PARITY == PAR_ODD) ? ~(^shift_q) : (^shift_q);

    assign pop_c = m_valid && m_ready;

    // Framing FSM: next state, datapath updates and error/push decisions.
    always_comb begin
        state_d   = state_q;
        tc_d      = tc_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        err_d     = '0;
        push_c    = 1'b0;
        align_c   = 1'b0;

        if (tick_c) begin
            tc_d = (tc_q == TC_W'(OVERSAMPLE - 1)) ? '0 : tc_q + TC_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    align_c   = 1'b1;
                    tc_d      = '0;
                    bit_d     = '0;
                    par_bad_d = 1'b0;
                end
            end
            ST_START: begin
                if (mid_c) begin
                    if (maj_c) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        tc_d    = '0;
                    end
                end
            end
            ST_DATA: begin
                if (sample_c) begin
                    shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BC_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BC_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (sample_c) begin
                    par_bad_d = (maj_c != par_exp_c);
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_c) begin
                    if (!maj_c) begin
                        err_d.frame = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end else if (bit_q == BC_W'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = ST_PUSH;
                    end else begin
                        bit_d = bit_q + BC_W'(1);
                    end
                end
            end
            ST_PUSH: begin
                state_d = ST_IDLE;
                if (par_bad_q) begin
                    err_d.parity = 1'b1;
                end else if (fifo_full && !pop_c) begin
                    err_d.overrun = 1'b1;
                end else begin
                    push_c = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tc_q      <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            tc_q      <= tc_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            err_q     <= err_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .wdata_i (shift_q),
        .full_o  (fifo_full),
        .pop_i   (m_ready),
        .rdata_o (m_data),
        .valid_o (m_valid)
    );

    assign frame_error  = err_q.frame;
    assign parity_error = err_q.parity;
    assign overrun      = err_q.overrun;
    assign rx_state     = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param. Instance A uses 8N2 framing, instance
// B uses 7E1. The line rate is raised above the default so the run stays
// short; the tick divisor still follows the same rounding rule.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned BAUD     = 781_250;
    localparam int unsigned OS       = 16;
    localparam int unsigned CLK_NS   = 20;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned DIV_TB   = (CLK_FREQ + (BAUD * OS) / 2) / (BAUD * OS);
    localparam int unsigned BIT_NS   = DIV_TB * OS * CLK_NS;

    logic       clk, rst_n;
    logic       rx_a, rx_b, rdy_a, rdy_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       val_a, val_b;
    logic       fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;
    logic [2:0] st_a, st_b;

    uart_rx_param #(
        .CLK_FREQ (CLK_FREQ), .BAUD_RATE (BAUD), .OVERSAMPLE (OS),
        .DATA_BITS (8), .STOP_BITS (2), .PARITY (PAR_NONE), .FIFO_DEPTH (DEPTH)
    ) u_dut_a (
        .clk (clk), .rst_n (rst_n), .rx_raw (rx_a),
        .m_data (data_a), .m_valid (val_a), .m_ready (rdy_a),
        .frame_error (fe_a), .parity_error (pe_a), .overrun (ov_a),
        .rx_state (st_a)
    );

    uart_rx_param #(
        .CLK_FREQ (CLK_FREQ), .BAUD_RATE (BAUD), .OVERSAMPLE (OS),
        .DATA_BITS (7), .STOP_BITS (1), .PARITY (PAR_EVEN), .FIFO_DEPTH (DEPTH)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n), .rx_raw (rx_b),
        .m_data (data_b), .m_valid (val_b), .m_ready (rdy_b),
        .frame_error (fe_b), .parity_error (pe_b), .overrun (ov_b),
        .rx_state (st_b)
    );

    initial clk = 1'b0;
    always #(CLK_NS / 2) clk = ~clk;

    // Observed traffic: accepted words and error pulse tallies.
    logic [7:0] got_a[$];
    logic [6:0] got_b[$];
    int fe_a_n = 0, pe_a_n = 0, ov_a_n = 0;
    int fe_b_n = 0, pe_b_n = 0, ov_b_n = 0;
    int coinc_n = 0;

    always @(negedge clk) begin
        if (val_a && rdy_a) got_a.push_back(data_a);
        if (val_b && rdy_b) got_b.push_back(data_b);
        if (fe_a) fe_a_n++;
        if (pe_a) pe_a_n++;
        if (ov_a) ov_a_n++;
        if (fe_b) fe_b_n++;
        if (pe_b) pe_b_n++;
        if (ov_b) ov_b_n++;
        if ((int'(fe_a) + int'(pe_a) + int'(ov_a)) > 1) coinc_n++;
        if ((int'(fe_b) + int'(pe_b) + int'(ov_b)) > 1) coinc_n++;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b, input logic v);
        if (b) rx_b = v;
        else   rx_a = v;
    endtask

    // One serial frame: start, LSB-first data, optional parity, stop bits.
    task automatic send_frame(input bit b, input logic [8:0] d, input int nbits,
                              input int par, input logic [1:0] stops, input int nstop);
        drive(b, 1'b0);
        #(BIT_NS);
        for (int i = 0; i < nbits; i++) begin
            drive(b, d[i]);
            #(BIT_NS);
        end
        if (par >= 0) begin
            drive(b, par[0]);
            #(BIT_NS);
        end
        for (int i = 0; i < nstop; i++) begin
            drive(b, stops[i]);
            #(BIT_NS);
        end
        drive(b, 1'b1);
    endtask

    task automatic send_a(input logic [7:0] d, input logic [1:0] stops);
        send_frame(1'b0, {1'b0, d}, 8, -1, stops, 2);
    endtask

    task automatic send_b(input logic [6:0] d, input int par, input logic stop);
        send_frame(1'b1, {2'b00, d}, 7, par, {1'b1, stop}, 1);
    endtask

    function automatic int even_par(input logic [6:0] d);
        return $countones(d) % 2;
    endfunction

    task automatic set_rdy_a(input logic v);
        @(posedge clk);
        #1 rdy_a = v;
    endtask

    logic [7:0] t1_words [11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                  8'h06, 8'h07, 8'hAA, 8'h55, 8'hFF};
    logic [7:0] exp_a[$];
    logic [6:0] exp_b[$];
    int base_a, base_b, fe0, pe0, ov0, exp_fe, exp_pe;
    logic [7:0] rd8;
    logic [6:0] rd7;
    logic [1:0] stops;
    int par_ok, stop_ok;

    initial begin
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        #105;
        chk("rst_valid_a", 32'(val_a), 32'd0);
        chk("rst_data_a",  32'(data_a), 32'd0);
        chk("rst_state_a", 32'(st_a), 32'(ST_IDLE));
        chk("rst_err_a",   32'({fe_a, pe_a, ov_a}), 32'd0);
        chk("rst_valid_b", 32'(val_b), 32'd0);
        chk("rst_state_b", 32'(st_b), 32'(ST_IDLE));
        rst_n = 1'b1;
        #(BIT_NS);

        // 1: back-to-back 8N2 words with the consumer always ready.
        base_a = got_a.size(); fe0 = fe_a_n; pe0 = pe_a_n; ov0 = ov_a_n;
        for (int i = 0; i < 11; i++) send_a(t1_words[i], 2'b11);
        #(2 * BIT_NS);
        chk("t1_beats", 32'(got_a.size() - base_a), 32'd11);
        for (int i = 0; i < 11; i++)
            if (base_a + i < got_a.size()) chk("t1_word", 32'(got_a[base_a + i]), 32'(t1_words[i]));
        chk("t1_errs", 32'((fe_a_n - fe0) + (pe_a_n - pe0) + (ov_a_n - ov0)), 32'd0);

        // 2: 7E1 with correct, then wrong, parity.
        base_b = got_b.size(); pe0 = pe_b_n;
        send_b(7'h35, even_par(7'h35), 1'b1);
        #(BIT_NS);
        chk("t2_good_count", 32'(got_b.size() - base_b), 32'd1);
        if (got_b.size() > base_b) chk("t2_good_word", 32'(got_b[base_b]), 32'h35);
        chk("t2_good_nope", 32'(pe_b_n - pe0), 32'd0);
        send_b(7'h35, 1 - even_par(7'h35), 1'b1);
        #(BIT_NS);
        chk("t2_bad_pe", 32'(pe_b_n - pe0), 32'd1);
        chk("t2_bad_count", 32'(got_b.size() - base_b), 32'd1);
        chk("t2_bad_fe", 32'(fe_b_n), 32'd0);

        // 3: first stop bit low followed by a held-low line (break).
        base_a = got_a.size(); fe0 = fe_a_n; pe0 = pe_a_n; ov0 = ov_a_n;
        rd8 = 8'hBD;
        drive(1'b0, 1'b0);
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, rd8[i]);
            #(BIT_NS);
        end
        drive(1'b0, 1'b0);
        #(3 * BIT_NS);
        chk("t3_state_wait", 32'(st_a), 32'(ST_WAIT_IDLE));
        chk("t3_fe", 32'(fe_a_n - fe0), 32'd1);
        chk("t3_no_push", 32'(got_a.size() - base_a), 32'd0);
        drive(1'b0, 1'b1);
        #(BIT_NS);
        chk("t3_state_idle", 32'(st_a), 32'(ST_IDLE));
        send_a(8'h12, 2'b11);
        #(BIT_NS);
        chk("t3_next_count", 32'(got_a.size() - base_a), 32'd1);
        if (got_a.size() > base_a) chk("t3_next_word", 32'(got_a[base_a]), 32'h12);
        chk("t3_other_errs", 32'((pe_a_n - pe0) + (ov_a_n - ov0) + (fe_a_n - fe0)), 32'd1);

        // 4: consumer stalled; FIFO fills and later words overrun.
        set_rdy_a(1'b0);
        base_a = got_a.size(); ov0 = ov_a_n; fe0 = fe_a_n;
        for (int i = 0; i < 6; i++) send_a(8'(8'h11 + i), 2'b11);
        #(BIT_NS);
        chk("t4_valid_held", 32'(val_a), 32'd1);
        chk("t4_head_held", 32'(data_a), 32'h11);
        chk("t4_overruns", 32'(ov_a_n - ov0), 32'(6 - DEPTH));
        chk("t4_no_pop", 32'(got_a.size() - base_a), 32'd0);
        set_rdy_a(1'b1);
        #(BIT_NS);
        chk("t4_drain_count", 32'(got_a.size() - base_a), 32'(DEPTH));
        for (int i = 0; i < int'(DEPTH); i++)
            if (base_a + i < got_a.size()) chk("t4_drain_word", 32'(got_a[base_a + i]), 32'(8'h11 + i));
        chk("t4_valid_empty", 32'(val_a), 32'd0);
        chk("t4_fe", 32'(fe_a_n - fe0), 32'd0);

        // 5: quarter-bit low glitch is rejected.
        base_a = got_a.size(); fe0 = fe_a_n; pe0 = pe_a_n; ov0 = ov_a_n;
        drive(1'b0, 1'b0);
        #(BIT_NS / 8);
        chk("t5_in_start", 32'(st_a), 32'(ST_START));
        #(BIT_NS / 8);
        drive(1'b0, 1'b1);
        #(BIT_NS);
        chk("t5_back_idle", 32'(st_a), 32'(ST_IDLE));
        chk("t5_no_push", 32'(got_a.size() - base_a), 32'd0);
        chk("t5_no_pulse", 32'((fe_a_n - fe0) + (pe_a_n - pe0) + (ov_a_n - ov0)), 32'd0);
        send_a(8'h99, 2'b11);
        #(BIT_NS);
        if (got_a.size() > base_a) chk("t5_word", 32'(got_a[base_a]), 32'h99);
        chk("t5_count", 32'(got_a.size() - base_a), 32'd1);

        // 6: reset in the middle of a frame with a word parked in the FIFO.
        set_rdy_a(1'b0);
        send_a(8'h77, 2'b11);
        #(BIT_NS);
        chk("t6_parked_valid", 32'(val_a), 32'd1);
        chk("t6_parked_data", 32'(data_a), 32'h77);
        fe0 = fe_a_n; pe0 = pe_a_n; ov0 = ov_a_n;
        rd8 = 8'h5A;
        drive(1'b0, 1'b0);
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, rd8[i]);
            #(BIT_NS);
        end
        drive(1'b0, rd8[3]);
        #(BIT_NS / 2);
        chk("t6_in_data", 32'(st_a), 32'(ST_DATA));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(val_a), 32'd0);
        chk("t6_rst_data", 32'(data_a), 32'd0);
        chk("t6_rst_state", 32'(st_a), 32'(ST_IDLE));
        #99;
        drive(1'b0, 1'b1);
        rst_n = 1'b1;
        #(2 * BIT_NS);
        chk("t6_post_state", 32'(st_a), 32'(ST_IDLE));
        chk("t6_post_valid", 32'(val_a), 32'd0);
        chk("t6_no_pulse", 32'((fe_a_n - fe0) + (pe_a_n - pe0) + (ov_a_n - ov0)), 32'd0);
        set_rdy_a(1'b1);
        base_a = got_a.size();
        send_a(8'h3C, 2'b11);
        #(BIT_NS);
        chk("t6_count", 32'(got_a.size() - base_a), 32'd1);
        if (got_a.size() > base_a) chk("t6_word", 32'(got_a[base_a]), 32'h3C);

        // 7: random 8N2 words, some with a corrupted stop bit.
        base_a = got_a.size(); fe0 = fe_a_n; pe0 = pe_a_n; ov0 = ov_a_n;
        exp_a.delete(); exp_fe = 0;
        for (int n = 0; n < 12; n++) begin
            rd8   = 8'($urandom_range(0, 255));
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            if (stops != 2'b11) exp_fe++;
            else                exp_a.push_back(rd8);
            send_a(rd8, stops);
            #(BIT_NS);
        end
        #(BIT_NS);
        chk("t7_count", 32'(got_a.size() - base_a), 32'(exp_a.size()));
        foreach (exp_a[i])
            if (base_a + i < got_a.size()) chk("t7_word", 32'(got_a[base_a + i]), 32'(exp_a[i]));
        chk("t7_fe", 32'(fe_a_n - fe0), 32'(exp_fe));
        chk("t7_pe_ov", 32'((pe_a_n - pe0) + (ov_a_n - ov0)), 32'd0);

        // 8: random 7E1 words with random parity and stop faults.
        base_b = got_b.size(); fe0 = fe_b_n; pe0 = pe_b_n; ov0 = ov_b_n;
        exp_b.delete(); exp_fe = 0; exp_pe = 0;
        for (int n = 0; n < 10; n++) begin
            rd7     = 7'($urandom_range(0, 127));
            par_ok  = ($urandom_range(0, 2) != 0) ? 1 : 0;
            stop_ok = ($urandom_range(0, 4) != 0) ? 1 : 0;
            if (stop_ok == 0)    exp_fe++;
            else if (par_ok == 0) exp_pe++;
            else                 exp_b.push_back(rd7);
            send_b(rd7, (par_ok != 0) ? even_par(rd7) : 1 - even_par(rd7), stop_ok[0]);
            #(BIT_NS);
        end
        #(BIT_NS);
        chk("t8_count", 32'(got_b.size() - base_b), 32'(exp_b.size()));
        foreach (exp_b[i])
            if (base_b + i < got_b.size()) chk("t8_word", 32'(got_b[base_b + i]), 32'(exp_b[i]));
        chk("t8_fe", 32'(fe_b_n - fe0), 32'(exp_fe));
        chk("t8_pe", 32'(pe_b_n - pe0), 32'(exp_pe));
        chk("t8_ov", 32'(ov_b_n - ov0), 32'd0);

        chk("pulse_overlap", 32'(coinc_n), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
